abro_stim_seq: RTL and testbench
================================

Name: abro_stim_seq

Overview:
- Stimulus sequencer that drives the A/B inputs of the ABRO detector and judges its O output.
- On each start it latches a configuration, then:
  - issues a one-cycle clear to the detector,
  - emits the A/B event pattern with programmed pulse length and gap,
  - watches O until it fires or a timeout expires,
  - reports pass/fail.
- Used in self-checking benches and on-board loopback tests in place of hand-written delay-based stimulus.

Parameters:
- GAP_W, 8: width of gap input; inter-event gap up to 2^GAP_W-1 cycles.
- PULSE_W, 4: width of pulse_len input.
- TIMEOUT, 16: cycles spent in WAIT without O before the run concludes.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- order  input  2  pattern:
  - 00: A then B.
  - 01: B then A.
  - 10: A and B together.
  - 11: A only.
- pulse_len  input  PULSE_W  cycles each event is held high; 0 is treated as 1.
- gap  input  GAP_W  idle cycles between first and second event; 0 means back-to-back.
- o_in  input  1  O output of the detector.
- abro_rst  output  1  clear pulse to the detector's reset.
- A  output  1  event A to the detector.
- B  output  1  event B to the detector.
- busy  output  1  high from CLEAR through WAIT.
- done  output  1  one-cycle pulse when the run concludes.
- pass  output  1  verdict; valid from done, held until the next accepted start or reset.
- o_seen  output  1  sticky: O observed during the current run.

Behaviour:
- Reset (synchronous): state=IDLE; abro_rst, A, B, busy, done, pass, o_seen all 0; counters 0. Reset mid-run aborts immediately, with no done pulse.
- All outputs are registered.
- States: IDLE, CLEAR, FIRST, GAP, SECOND, WAIT, DONE.
- IDLE:
  - On start=1, latch order, pulse_len (0 becomes 1), and gap.
  - Clear o_seen and pass.
  - Next state is CLEAR.
  - start=0 holds IDLE.
- CLEAR: abro_rst=1 for exactly 1 cycle; next state is FIRST.
- FIRST: drive for pulse_len cycles, then:
  - order 00: A=1; next GAP.
  - order 01: B=1; next GAP.
  - order 10: A=B=1; next WAIT.
  - order 11: A=1; next WAIT.
- GAP:
  - A=B=0 for gap cycles, then SECOND.
  - gap=0: FIRST goes directly to SECOND with no low cycle between pulses.
- SECOND:
  - Drive the other event (B for order 00, A for order 01) for pulse_len cycles.
  - Next state is WAIT.
- WAIT:
  - A=B=0; cycle counter starts at 0.
  - Exit to DONE in the cycle o_in=1 is sampled, or after TIMEOUT cycles, whichever comes first.
- o_seen:
  - Set on any cycle with o_in=1 in states FIRST, GAP, SECOND, or WAIT.
  - Never set in CLEAR.
  - Stays set until the next accepted start.
- Expected O: 1 for order 00, 01, and 10; 0 for order 11.
- DONE: done=1 for 1 cycle; pass = (o_seen == expected O); next state is IDLE.
- busy is 1 in CLEAR, FIRST, GAP, SECOND, and WAIT; 0 in IDLE and DONE.
- start while busy or in DONE is ignored; it is not queued.
- Latency from start to first A/B high: 2 cycles.
  - Cycle 1: start sampled, transition to CLEAR.
  - Cycle 2: abro_rst asserted.
  - Following cycle: pulse begins.
- Counters saturate safely. The maximum gap (2^GAP_W-1) and maximum pulse_len must run to completion without wrap.
- Simultaneous o_in=1 and timeout expiry in the same WAIT cycle: O wins, o_seen=1.

Test Plan:
- Start with order=00, pulse_len=2, gap=3; the detector asserts O 1 cycle after B.
  - Required: A high 2 cycles, 3 low, B high 2 cycles.
  - Required: done pulse with pass=1, o_seen=1.
- Order=11, pulse_len=1; the detector never asserts O.
  - Required: WAIT lasts exactly TIMEOUT=16 cycles.
  - Required: done with pass=1, o_seen=0.
- Order=01, pulse_len=0, gap=0.
  - Required: B high 1 cycle immediately followed by A high 1 cycle, with no low cycle between.
  - Required: abro_rst high exactly 1 cycle beforehand.
- Order=10 with o_in tied 0.
  - Required: A and B high together for pulse_len cycles.
  - Required: timeout after 16 cycles; done with pass=0.
- Start asserted during GAP, plus a second start in the DONE cycle: both ignored; exactly one done pulse per accepted start.
- Reset asserted during SECOND.
  - Required: next cycle state is IDLE; A, B, busy, done, pass, o_seen all 0.
  - Required: no done pulse.
  - Required: a subsequent start runs normally.

Source files
------------

// File: rtl/abro_stim_seq.sv
// Stimulus sequencer for the ABRO detector: clears the detector, plays an
// A/B event pattern with programmable pulse length and gap, then watches
// the detector's O output and reports a pass/fail verdict.
module abro_stim_seq #(
  parameter int GAP_W   = 8,
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         order,
  input  logic [PULSE_W-1:0] pulse_len,
  input  logic [GAP_W-1:0]   gap,
  input  logic               o_in,
  output logic               abro_rst,
  output logic               A,
  output logic               B,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               o_seen
);

  // One shared counter serves pulse, gap and timeout phases, so it must be
  // wide enough for the largest of the three terminal values.
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int GP_MAX = (GAP_W > PULSE_W) ? GAP_W : PULSE_W;
  localparam int CNT_W  = (GP_MAX > TO_W) ? GP_MAX : TO_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FIRST,
    GAP,
    SECOND,
    WAIT,
    DONE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         order_q;
  logic [PULSE_W-1:0] plen_q;
  logic [GAP_W-1:0]   gap_q;
  logic               abroRst_q;
  logic               a_q;
  logic               b_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               oSeen_q;

  logic [CNT_W-1:0]   cntInc_d;
  logic               pulseEnd_d;
  logic               gapEnd_d;
  logic               timeoutEnd_d;
  logic               oSeen_d;
  logic               expO_d;
  logic               firstA_d;
  logic               firstB_d;
  logic               secondA_d;
  logic               secondB_d;

  // Phase-end tests compare the incremented count against the latched length,
  // so the counter never has to hold the terminal value itself and cannot wrap.
  assign cntInc_d     = cnt_q + CNT_ONE;
  assign pulseEnd_d   = (cntInc_d == CNT_W'(plen_q));
  assign gapEnd_d     = (cntInc_d == CNT_W'(gap_q));
  assign timeoutEnd_d = (cntInc_d == CNT_W'(TIMEOUT));
  assign oSeen_d      = oSeen_q | o_in;

  // Pattern decode from the latched order: which events go in each slot and
  // whether the detector is expected to fire at all (A-only never completes).
  assign firstA_d  = (order_q != 2'b01);
  assign firstB_d  = (order_q == 2'b01) || (order_q == 2'b10);
  assign secondA_d = (order_q == 2'b01);
  assign secondB_d = (order_q == 2'b00);
  assign expO_d    = (order_q != 2'b11);

  // Sequencer FSM; every output is a register updated alongside the state
  // so it lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      order_q   <= '0;
      plen_q    <= '0;
      gap_q     <= '0;
      abroRst_q <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      oSeen_q   <= 1'b0;
    end else begin
      abroRst_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            order_q   <= order;
            plen_q    <= (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
            gap_q     <= gap;
            oSeen_q   <= 1'b0;
            pass_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            abroRst_q <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_q   <= '0;
          a_q     <= firstA_d;
          b_q     <= firstB_d;
          state_q <= FIRST;
        end
        FIRST: begin
          oSeen_q <= oSeen_d;
          if (pulseEnd_d) begin
            cnt_q <= '0;
            if (order_q[1]) begin
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              state_q <= WAIT;
            end else if (gap_q == '0) begin
              a_q     <= secondA_d;
              b_q     <= secondB_d;
              state_q <= SECOND;
            end else begin
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              state_q <= GAP;
            end
          end else begin
            cnt_q <= cntInc_d;
          end
        end
        GAP: begin
          oSeen_q <= oSeen_d;
          if (gapEnd_d) begin
            cnt_q   <= '0;
            a_q     <= secondA_d;
            b_q     <= secondB_d;
            state_q <= SECOND;
          end else begin
            cnt_q <= cntInc_d;
          end
        end
        SECOND: begin
          oSeen_q <= oSeen_d;
          if (pulseEnd_d) begin
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            state_q <= WAIT;
          end else begin
            cnt_q <= cntInc_d;
          end
        end
        WAIT: begin
          oSeen_q <= oSeen_d;
          if (o_in || timeoutEnd_d) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (oSeen_d == expO_d);
            state_q <= DONE;
          end else begin
            cnt_q <= cntInc_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign abro_rst = abroRst_q;
  assign A        = a_q;
  assign B        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign o_seen   = oSeen_q;

endmodule

// File: tb/tb_abro_stim_seq.sv
// Testbench for abro_stim_seq: plays directed and random runs, emulates an
// ABRO detector on the loopback, and compares every cycle against a trace
// built from the pattern rules.
module tb_abro_stim_seq;

  localparam int GAP_W   = 8;
  localparam int PULSE_W = 4;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         order;
  logic [PULSE_W-1:0] pulse_len;
  logic [GAP_W-1:0]   gap;
  logic               o_in;
  logic               abro_rst;
  logic               A;
  logic               B;
  logic               busy;
  logic               done;
  logic               pass;
  logic               o_seen;

  int errors = 0;
  int checks = 0;

  bit seenA;
  bit seenB;
  bit armed;
  bit oLvl;
  int timer;
  int detMode;
  int detDelay;
  bit expSeen;

  always #5 clk = ~clk;

  abro_stim_seq #(
    .GAP_W  (GAP_W),
    .PULSE_W(PULSE_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .order    (order),
    .pulse_len(pulse_len),
    .gap      (gap),
    .o_in     (o_in),
    .abro_rst (abro_rst),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .o_seen   (o_seen)
  );

  // Single comparison point: counts, and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compares the whole per-cycle output vector, including the sticky O flag.
  task automatic checkCycle(input string ph, input logic eRst, input logic eA,
                            input logic eB, input logic eBusy, input logic eDone);
    checkOutput($sformatf("%s.abro_rst", ph), abro_rst, eRst);
    checkOutput($sformatf("%s.A", ph), A, eA);
    checkOutput($sformatf("%s.B", ph), B, eB);
    checkOutput($sformatf("%s.busy", ph), busy, eBusy);
    checkOutput($sformatf("%s.done", ph), done, eDone);
    checkOutput($sformatf("%s.o_seen", ph), o_seen, expSeen);
  endtask

  // Emulated detector: O rises detDelay cycles after both A and B have been
  // seen since the last clear, and stays high; mode 0 ties O low, mode 2 is noise.
  task automatic driveDetector(input bit inClear);
    if (abro_rst) begin
      seenA = 1'b0;
      seenB = 1'b0;
      armed = 1'b0;
      oLvl  = 1'b0;
    end else begin
      seenA = seenA | A;
      seenB = seenB | B;
      if (!armed && seenA && seenB) begin
        armed = 1'b1;
        timer = detDelay;
      end else if (armed && timer > 0) begin
        timer--;
      end
      oLvl = armed && (timer == 0);
    end
    case (detMode)
      0:       o_in = 1'b0;
      1:       o_in = oLvl;
      default: o_in = ($urandom_range(0, 7) == 0);
    endcase
    if (!inClear) expSeen = expSeen | o_in;
  endtask

  task automatic applyStimulus(input logic [1:0] ord, input logic [PULSE_W-1:0] plen,
                               input logic [GAP_W-1:0] gp);
    order     = ord;
    pulse_len = plen;
    gap       = gp;
    start     = 1'b1;
  endtask

  // One complete run: expected {abro_rst,A,B} trace from CLEAR to the end of
  // the pattern, then a WAIT phase bounded by TIMEOUT, then DONE and IDLE.
  task automatic runTest(input logic [1:0] ord, input logic [PULSE_W-1:0] plen,
                         input logic [GAP_W-1:0] gp, input int mode, input int dly,
                         input bit injectStart, input bit abortSecond);
    logic [2:0] trace[$];
    int  p;
    int  gapStart;
    int  secondStart;
    bit  twoEv;
    bit  expO;
    bit  oHit;
    bit  expPass;
    int  waitCnt;
    logic fa, fb, sa, sb;
    p     = (plen == 0) ? 1 : int'(plen);
    twoEv = (ord == 2'b00) || (ord == 2'b01);
    fa    = (ord != 2'b01);
    fb    = (ord == 2'b01) || (ord == 2'b10);
    sa    = (ord == 2'b01);
    sb    = (ord == 2'b00);
    expO  = (ord != 2'b11);
    trace.push_back(3'b100);
    repeat (p) trace.push_back({1'b0, fa, fb});
    gapStart    = trace.size();
    secondStart = -1;
    if (twoEv) begin
      repeat (int'(gp)) trace.push_back(3'b000);
      secondStart = trace.size();
      repeat (p) trace.push_back({1'b0, sa, sb});
    end
    detMode  = mode;
    detDelay = dly;
    applyStimulus(ord, plen, gp);
    expSeen = 1'b0;
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) begin
        order     = 2'($urandom);
        pulse_len = PULSE_W'($urandom);
        gap       = GAP_W'($urandom);
      end
      checkCycle((i == 0) ? "clear" : "pattern", trace[i][2], trace[i][1], trace[i][0], 1'b1, 1'b0);
      driveDetector(i == 0);
      if (injectStart && twoEv && gp != 0 && i == gapStart) start = 1'b1;
      if (abortSecond && i == secondStart) begin
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        expSeen = 1'b0;
        checkCycle("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort.pass", pass, 1'b0);
        o_in = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkCycle("abortIdle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
    end
    waitCnt = 0;
    oHit    = 1'b0;
    while (!oHit && waitCnt < TIMEOUT) begin
      @(negedge clk);
      start = 1'b0;
      checkCycle("wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      driveDetector(1'b0);
      waitCnt++;
      if (o_in) oHit = 1'b1;
    end
    @(negedge clk);
    expPass = (expSeen == expO);
    checkCycle("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("done.pass", pass, expPass);
    if (injectStart) start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      start = 1'b0;
      o_in  = 1'b0;
      checkCycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("idle.passHeld", pass, expPass);
    end
  endtask

  // Directed scenarios first, then randomized runs, then the summary.
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    order     = 2'b00;
    pulse_len = '0;
    gap       = '0;
    o_in      = 1'b0;
    expSeen   = 1'b0;
    detMode   = 0;
    detDelay  = 0;
    timer     = 0;
    repeat (2) @(negedge clk);
    checkCycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.pass", pass, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkCycle("postReset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] order 00, pulse 2, gap 3");
    runTest(2'b00, 4'd2, 8'd3, 1, 1, 1'b0, 1'b0);
    $display("[TB] order 11, detector silent, full timeout");
    runTest(2'b11, 4'd1, 8'd0, 1, 0, 1'b0, 1'b0);
    $display("[TB] order 01, pulse 0, gap 0");
    runTest(2'b01, 4'd0, 8'd0, 1, 0, 1'b0, 1'b0);
    $display("[TB] order 10, O tied low");
    runTest(2'b10, 4'd5, 8'd7, 0, 0, 1'b0, 1'b0);
    $display("[TB] start during GAP and DONE");
    runTest(2'b00, 4'd3, 8'd4, 1, 2, 1'b1, 1'b0);
    $display("[TB] reset during SECOND, then a normal run");
    runTest(2'b01, 4'd2, 8'd3, 1, 0, 1'b0, 1'b1);
    runTest(2'b00, 4'd1, 8'd1, 1, 0, 1'b0, 1'b0);
    $display("[TB] O on the last WAIT cycle, and one cycle too late");
    runTest(2'b10, 4'd1, 8'd0, 1, TIMEOUT, 1'b0, 1'b0);
    runTest(2'b10, 4'd1, 8'd0, 1, TIMEOUT + 1, 1'b0, 1'b0);
    $display("[TB] maximum pulse and gap");
    runTest(2'b00, 4'd15, 8'd255, 1, 0, 1'b0, 1'b0);
    $display("[TB] noise on O, order 11");
    runTest(2'b11, 4'd3, 8'd2, 2, 0, 1'b0, 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 30; r++) begin
      runTest(2'($urandom), PULSE_W'($urandom), GAP_W'($urandom_range(0, 12)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 20)),
              1'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
